// File: rtl/thrust_velocity_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// thrust_velocity_ctrl_pkg
//
// Shared definitions for the thrust/velocity controller:
//   - burn opcode encodings (op_e)
//   - controller FSM state encodings (state_e)
//   - axis indices
//   - one-hot position-unit select codes
//   - default datapath widths and the velocity clamp limit
// ---------------------------------------------------------------------------
package thrust_velocity_ctrl_pkg;

    // Default widths: 4-bit velocity magnitude (matches the add/sub datapath
    // of the position units) and a 4-bit burn-duration field.
    localparam int VW_DEF = 4;
    localparam int DW_DEF = 4;

    // Largest velocity magnitude representable on the position datapath.
    localparam int VMAX = (1 << VW_DEF) - 1;

    // Burn command opcodes as they appear on cmd_op.
    typedef enum logic [1:0] {
        OP_BRAKE = 2'b00,
        OP_TPOS  = 2'b01,
        OP_TNEG  = 2'b10,
        OP_HOME  = 2'b11
    } op_e;

    // Controller states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BURN = 2'd1,
        S_HOME = 2'd2
    } state_e;

    // Axis indices as they appear on cmd_axis. Index 3 is illegal.
    localparam logic [1:0] AXIS_X   = 2'd0;
    localparam logic [1:0] AXIS_Y   = 2'd1;
    localparam logic [1:0] AXIS_Z   = 2'd2;
    localparam logic [1:0] AXIS_BAD = 2'd3;

    // One-hot channel selects for a position unit.
    localparam logic [3:0] SEL_HOLD = 4'b0001;
    localparam logic [3:0] SEL_ADD  = 4'b0010;
    localparam logic [3:0] SEL_SUB  = 4'b0100;
    localparam logic [3:0] SEL_HOME = 4'b1000;

endpackage : thrust_velocity_ctrl_pkg

// File: rtl/thrust_velocity_ctrl_vel_step_sat.sv
// ---------------------------------------------------------------------------
// vel_step_sat
//
// Combinational single-step velocity update with saturation.
//   v_i  : current signed velocity, (VW+1)-bit two's complement
//   op_i : burn opcode
//   v_o  : velocity after one step
//     OP_TPOS  : v+1, clamped at +VMAX
//     OP_TNEG  : v-1, clamped at -VMAX
//     OP_BRAKE : one step toward zero, zero stays zero
//     OP_HOME  : unchanged (homing clears velocity in the controller)
// ---------------------------------------------------------------------------
module vel_step_sat
    import thrust_velocity_ctrl_pkg::*;
#(
    parameter int VW = VW_DEF
) (
    input  logic signed [VW:0] v_i,
    input  op_e                op_i,
    output logic signed [VW:0] v_o
);

    localparam logic signed [VW:0] VPOS = (VW + 1)'((1 << VW) - 1);
    localparam logic signed [VW:0] VNEG = -VPOS;
    localparam logic signed [VW:0] ONE  = (VW + 1)'(1);
    localparam logic signed [VW:0] ZERO = '0;

    always_comb begin
        v_o = v_i;
        case (op_i)
            OP_TPOS: begin
                if (v_i < VPOS) v_o = v_i + ONE;
            end
            OP_TNEG: begin
                if (v_i > VNEG) v_o = v_i - ONE;
            end
            OP_BRAKE: begin
                if (v_i > ZERO)      v_o = v_i - ONE;
                else if (v_i < ZERO) v_o = v_i + ONE;
            end
            default: v_o = v_i;
        endcase
    end

endmodule : vel_step_sat

// File: rtl/thrust_velocity_ctrl.sv
// ---------------------------------------------------------------------------
// thrust_velocity_ctrl
//
// Holds a signed velocity per axis (X, Y, Z) and integrates burn commands
// into it one step per clock. Drives each axis position unit with a
// velocity magnitude, a direction bit and a one-hot channel select.
//
// Ports:
//   clk        : system clock, all state on the rising edge
//   rst_n      : asynchronous active-low reset
//   cmd_valid  : command present
//   cmd_ready  : command can be accepted (high only in IDLE)
//   cmd_axis   : 0=X, 1=Y, 2=Z, 3=illegal
//   cmd_op     : 00=BRAKE, 01=THRUST_POS, 10=THRUST_NEG, 11=HOME
//   cmd_dur    : burn length in clock steps
//   cmd_abort  : terminate the current burn
//   cmd_err    : one-cycle pulse after an illegal-axis command is accepted
//   busy       : high in BURN or HOME
//   vel_mag    : |v| per axis, X in [VW-1:0], then Y, Z on top
//   vel_dir    : per axis sign of v (1 = subtract)
//   pos_sel    : per axis one-hot select, X in [3:0]
//                bit0 hold, bit1 add, bit2 subtract, bit3 home
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. The sender must hold the command stable while
// cmd_ready is low; nothing is sampled from cmd_* outside that transfer
// except cmd_abort, which is only looked at in BURN.
// ---------------------------------------------------------------------------
module thrust_velocity_ctrl
    import thrust_velocity_ctrl_pkg::*;
#(
    parameter int VW = VW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_axis,
    input  logic [1:0]      cmd_op,
    input  logic [DW-1:0]   cmd_dur,
    input  logic            cmd_abort,
    output logic            cmd_err,
    output logic            busy,
    output logic [3*VW-1:0] vel_mag,
    output logic [2:0]      vel_dir,
    output logic [11:0]     pos_sel
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                state_q;
    logic [1:0]            axis_q;
    op_e                   op_q;
    logic [DW-1:0]         cnt_q;
    logic                  err_q;
    logic signed [VW:0]    vel_q [3];

    // ------------------------------------------------------------------
    // Shared step datapath: one saturating stepper on the target axis
    // ------------------------------------------------------------------
    logic signed [VW:0]    tgt_v;
    logic signed [VW:0]    step_v;

    always_comb begin
        case (axis_q)
            AXIS_Y:  tgt_v = vel_q[1];
            AXIS_Z:  tgt_v = vel_q[2];
            default: tgt_v = vel_q[0];
        endcase
    end

    vel_step_sat #(
        .VW (VW)
    ) u_step (
        .v_i  (tgt_v),
        .op_i (op_q),
        .v_o  (step_v)
    );

    // A BRAKE burn ends as soon as the stepped velocity is zero; this also
    // covers a BRAKE issued while already stopped, which spends one cycle
    // in BURN and leaves on the next edge.
    logic brake_done;
    logic last_step;

    assign brake_done = (op_q == OP_BRAKE) && (step_v == '0);
    assign last_step  = (cnt_q == DW'(1));

    // ------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            axis_q  <= AXIS_X;
            op_q    <= OP_BRAKE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                vel_q[i] <= '0;
            end
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_axis == AXIS_BAD) begin
                            // Rejected: flag it and keep everything else.
                            err_q <= 1'b1;
                        end else begin
                            axis_q <= cmd_axis;
                            op_q   <= op_e'(cmd_op);
                            cnt_q  <= cmd_dur;
                            if (op_e'(cmd_op) == OP_HOME) begin
                                state_q <= S_HOME;
                            end else if (cmd_dur != '0) begin
                                state_q <= S_BURN;
                            end
                        end
                    end
                end

                S_BURN: begin
                    if (cmd_abort) begin
                        // Abort wins over a pending final step.
                        state_q <= S_IDLE;
                    end else begin
                        for (int i = 0; i < 3; i++) begin
                            if (axis_q == 2'(i)) vel_q[i] <= step_v;
                        end
                        cnt_q <= cnt_q - DW'(1);
                        if (last_step || brake_done) begin
                            state_q <= S_IDLE;
                        end
                    end
                end

                S_HOME: begin
                    // Position unit sees SEL_HOME for this one cycle;
                    // the axis comes out of it at rest.
                    for (int i = 0; i < 3; i++) begin
                        if (axis_q == 2'(i)) vel_q[i] <= '0;
                    end
                    state_q <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state only
    // ------------------------------------------------------------------
    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_BURN) || (state_q == S_HOME);
    assign cmd_err   = err_q;

    for (genvar g = 0; g < 3; g++) begin : g_axis
        logic signed [VW:0] v;
        logic signed [VW:0] v_neg;
        logic               home_here;

        assign v         = vel_q[g];
        assign v_neg     = -v;
        assign home_here = (state_q == S_HOME) && (axis_q == 2'(g));

        // Clamp keeps |v| <= VMAX, so the magnitude always fits in VW bits.
        assign vel_mag[g*VW +: VW] = v[VW] ? v_neg[VW-1:0] : v[VW-1:0];
        assign vel_dir[g]          = v[VW];
        assign pos_sel[g*4 +: 4]   = home_here ? SEL_HOME :
                                     (v == '0) ? SEL_HOLD :
                                     v[VW]     ? SEL_SUB  : SEL_ADD;
    end

endmodule : thrust_velocity_ctrl

// File: tb/tb_thrust_velocity_ctrl.sv
// ---------------------------------------------------------------------------
// tb_thrust_velocity_ctrl
//
// Directed bench for thrust_velocity_ctrl. The bench keeps its own per-axis
// velocity model (vx/vy/vz); each step packs the expected outputs from that
// model into exp_q, advances one clock, and compares the DUT outputs against
// the popped expectation on the falling edge.
// ---------------------------------------------------------------------------
module tb_thrust_velocity_ctrl;
  import thrust_velocity_ctrl_pkg::*;

  localparam int VW = 4;
  localparam int DW = 4;
  localparam int W  = 3 + 3 * VW + 3 + 12;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_axis;
  logic [1:0]      cmd_op;
  logic [DW-1:0]   cmd_dur;
  logic            cmd_abort;
  logic            cmd_err;
  logic            busy;
  logic [3*VW-1:0] vel_mag;
  logic [2:0]      vel_dir;
  logic [11:0]     pos_sel;

  always #5 clk = ~clk;

  thrust_velocity_ctrl #(.VW(VW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_axis  (cmd_axis),
    .cmd_op    (cmd_op),
    .cmd_dur   (cmd_dur),
    .cmd_abort (cmd_abort),
    .cmd_err   (cmd_err),
    .busy      (busy),
    .vel_mag   (vel_mag),
    .vel_dir   (vel_dir),
    .pos_sel   (pos_sel)
  );

  // ---------------- model + scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int vx, vy, vz;

  function automatic logic [W-1:0] model(bit rdy, bit bsy, bit err, int home_ax);
    logic [3*VW-1:0] mag;
    logic [2:0]      dir;
    logic [11:0]     sel;
    int              v;
    mag = '0;
    dir = '0;
    sel = '0;
    for (int a = 0; a < 3; a++) begin
      v = (a == 0) ? vx : (a == 1) ? vy : vz;
      mag[a*VW +: VW] = VW'((v < 0) ? -v : v);
      dir[a]          = (v < 0);
      if (home_ax == a)  sel[a*4 +: 4] = 4'b1000;
      else if (v == 0)   sel[a*4 +: 4] = 4'b0001;
      else if (v > 0)    sel[a*4 +: 4] = 4'b0010;
      else               sel[a*4 +: 4] = 4'b0100;
    end
    return {rdy, bsy, err, mag, dir, sel};
  endfunction

  task automatic push_exp(bit rdy, bit bsy, bit err, int home_ax);
    exp_q.push_back(model(rdy, bsy, err, home_ax));
  endtask

  task automatic check(string tag);
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    act_v = {cmd_ready, busy, cmd_err, vel_mag, vel_dir, pos_sel};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $error("FAIL %s: observed %h but expectation queue empty", tag, act_v);
    end else begin
      exp_v = exp_q.pop_front();
      assert (act_v === exp_v) else begin
        n_bad++;
        $error("FAIL %s: observed %h expected %h", tag, act_v, exp_v);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Push the post-edge expectation, advance one clock, compare.
  task automatic cyc(string tag, bit rdy, bit bsy, bit err, int home_ax);
    push_exp(rdy, bsy, err, home_ax);
    @(posedge clk);
    @(negedge clk);
    check(tag);
  endtask

  // Present a command for one edge (accepted when the DUT is idle).
  task automatic issue(string tag, int ax, logic [1:0] op, int dur,
                       bit rdy, bit bsy, bit err, int home_ax);
    cmd_valid = 1'b1;
    cmd_axis  = 2'(ax);
    cmd_op    = op;
    cmd_dur   = DW'(dur);
    cyc(tag, rdy, bsy, err, home_ax);
    cmd_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_axis  = '0;
    cmd_op    = '0;
    cmd_dur   = '0;
    cmd_abort = 1'b0;
    vx = 0; vy = 0; vz = 0;

    // Reset values
    @(negedge clk);
    push_exp(1, 0, 0, -1);
    check("reset");
    rst_n = 1'b1;
    cyc("idle", 1, 0, 0, -1);

    // X THRUST_POS dur=3: 1,2,3 then ready
    issue("x_acc", 0, OP_TPOS, 3, 0, 1, 0, -1);
    for (int i = 1; i <= 3; i++) begin
      vx = i;
      cyc("x_tpos", i == 3, i != 3, 0, -1);
    end

    // Y THRUST_NEG dur=15 down to -15, then dur=5 holds -15
    issue("y_acc", 1, OP_TNEG, 15, 0, 1, 0, -1);
    for (int i = 1; i <= 15; i++) begin
      vy = -i;
      cyc("y_tneg", i == 15, i != 15, 0, -1);
    end
    issue("y_sat_acc", 1, OP_TNEG, 5, 0, 1, 0, -1);
    for (int i = 1; i <= 5; i++) begin
      cyc("y_sat", i == 5, i != 5, 0, -1);
    end

    // Z to +2, then BRAKE dur=10 exits early after two steps
    issue("z_acc", 2, OP_TPOS, 2, 0, 1, 0, -1);
    vz = 1; cyc("z_tpos", 0, 1, 0, -1);
    vz = 2; cyc("z_tpos", 1, 0, 0, -1);
    issue("z_brk_acc", 2, OP_BRAKE, 10, 0, 1, 0, -1);
    vz = 1; cyc("z_brk", 0, 1, 0, -1);
    vz = 0; cyc("z_brk_end", 1, 0, 0, -1);
    cyc("z_idle", 1, 0, 0, -1);

    // X to +5, THRUST_NEG dur=8 aborted after 4 steps at +1
    issue("x_acc2", 0, OP_TPOS, 2, 0, 1, 0, -1);
    vx = 4; cyc("x_tpos2", 0, 1, 0, -1);
    vx = 5; cyc("x_tpos2", 1, 0, 0, -1);
    issue("x_neg_acc", 0, OP_TNEG, 8, 0, 1, 0, -1);
    for (int i = 1; i <= 4; i++) begin
      vx = 5 - i;
      cyc("x_tneg", 0, 1, 0, -1);
    end
    cmd_abort = 1'b1;
    cyc("x_abort", 1, 0, 0, -1);
    cmd_abort = 1'b0;

    // X crosses zero: +1 -> 0 -> -1
    issue("x_cross_acc", 0, OP_TNEG, 2, 0, 1, 0, -1);
    vx = 0;  cyc("x_zero", 0, 1, 0, -1);
    vx = -1; cyc("x_neg", 1, 0, 0, -1);

    // Illegal axis: one-cycle error pulse, nothing else moves
    issue("bad_axis", 3, OP_TPOS, 5, 1, 0, 1, -1);
    cyc("err_clear", 1, 0, 0, -1);

    // Zero-duration burn is a no-op; abort in IDLE is ignored
    issue("dur0", 0, OP_TPOS, 0, 1, 0, 0, -1);
    cmd_abort = 1'b1;
    cyc("abort_idle", 1, 0, 0, -1);
    cmd_abort = 1'b0;

    // Y BRAKE dur=8 from -15 to -7 (ends on count), then HOME on Y
    issue("y_brk_acc", 1, OP_BRAKE, 8, 0, 1, 0, -1);
    for (int i = 1; i <= 8; i++) begin
      vy = -15 + i;
      cyc("y_brk", i == 8, i != 8, 0, -1);
    end
    issue("y_home", 1, OP_HOME, 0, 0, 1, 0, 1);
    vy = 0;
    cyc("y_home_exit", 1, 0, 0, -1);

    // Abort on the edge of the final count: no step applied
    issue("x_one_acc", 0, OP_TPOS, 1, 0, 1, 0, -1);
    cmd_abort = 1'b1;
    cyc("abort_last", 1, 0, 0, -1);
    cmd_abort = 1'b0;

    // BRAKE entered at v=0 leaves after one cycle
    issue("z_brk0_acc", 2, OP_BRAKE, 5, 0, 1, 0, -1);
    cyc("z_brk0_end", 1, 0, 0, -1);

    // Reset asserted mid-burn
    issue("x_long_acc", 0, OP_TPOS, 10, 0, 1, 0, -1);
    vx = 0; cyc("x_long", 0, 1, 0, -1);
    vx = 1; cyc("x_long", 0, 1, 0, -1);
    #2;
    rst_n = 1'b0;
    #1;
    vx = 0; vy = 0; vz = 0;
    push_exp(1, 0, 0, -1);
    check("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post_reset", 1, 0, 0, -1);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_thrust_velocity_ctrl
